// File: rtl/beat_pkg.sv
// beat_pkg: shared beat-code constants, FSM state type and duration table
// for the beat_timer note-duration timer.
package beat_pkg;

  localparam logic [3:0] BEAT_WHOLE   = 4'd1;
  localparam logic [3:0] BEAT_HALF    = 4'd2;
  localparam logic [3:0] BEAT_QUARTER = 4'd3;
  localparam logic [3:0] BEAT_8TH     = 4'd4;
  localparam logic [3:0] BEAT_16TH    = 4'd5;
  localparam logic [3:0] BEAT_32ND    = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_e;

  function automatic logic beat_valid(input logic [3:0] code);
    return (code >= BEAT_WHOLE) && (code <= BEAT_32ND);
  endfunction

  // Base duration in cycles for a beat code, q = cycles per quarter note.
  function automatic logic [63:0] beat_base(
    input logic [3:0]  code,
    input logic [63:0] q
  );
    logic [63:0] r;
    r = '0;
    unique case (1'b1)
      (code == BEAT_WHOLE):   r = q << 2;
      (code == BEAT_HALF):    r = q << 1;
      (code == BEAT_QUARTER): r = q;
      (code == BEAT_8TH):     r = q >> 1;
      (code == BEAT_16TH):    r = q >> 2;
      (code == BEAT_32ND):    r = q >> 3;
      default:                r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/beat_len_lut.sv
// beat_len_lut: combinational beat code -> note duration lookup.
// BEAT_TIMER_DOT_EN builds the dotted-note adder; otherwise dotted is ignored.
module beat_len_lut
  import beat_pkg::*;
#(
  parameter int unsigned CNT_W          = 28,
  parameter int unsigned QUARTER_CYCLES = 20000000
) (
  input  logic [3:0]       beat_i,
  input  logic             dotted_i,
  output logic [CNT_W-1:0] dur_o,
  output logic             valid_o
);

  logic [63:0]      base;
  logic [CNT_W-1:0] base_w;
  logic             unused_ok;

  assign base    = beat_base(beat_i, 64'(QUARTER_CYCLES));
  assign base_w  = base[CNT_W-1:0];
  assign valid_o = beat_valid(beat_i);

`ifdef BEAT_TIMER_DOT_EN
  assign dur_o     = dotted_i ? base_w + (base_w >> 1) : base_w;
  assign unused_ok = ^base[63:CNT_W];
`else
  assign dur_o     = base_w;
  assign unused_ok = ^{dotted_i, base[63:CNT_W]};
`endif

endmodule

// File: rtl/beat_timer.sv
// beat_timer: times one note (tone part + articulation gap) per accepted start.
// Optional dotted notes via BEAT_TIMER_DOT_EN (see beat_len_lut).
module beat_timer
  import beat_pkg::*;
#(
  parameter int unsigned CNT_W          = 28,
  parameter int unsigned QUARTER_CYCLES = 20000000,
  parameter int unsigned GAP_CYCLES     = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] beat,
  input  logic       dotted,
  input  logic       pause,
  input  logic       stop,
  output logic       ready,
  output logic       busy,
  output logic       note_on,
  output logic       done,
  output logic       err
);

  localparam logic [CNT_W-1:0] GAP = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dur;
  logic             dur_ok;
  logic             accept, hold, last;

  logic ready_q, busy_q, note_q, done_q, err_q;
  logic ready_d, busy_d, note_d, done_d, err_d;

  beat_len_lut #(
    .CNT_W         (CNT_W),
    .QUARTER_CYCLES(QUARTER_CYCLES)
  ) u_lut (
    .beat_i  (beat),
    .dotted_i(dotted),
    .dur_o   (dur),
    .valid_o (dur_ok)
  );

  assign accept = start && (state_q != ST_ACTIVE);
  assign hold   = (state_q == ST_ACTIVE) && pause;
  // cnt_q holds the busy cycles still to run, including the current one.
  assign last   = cnt_q <= ONE;

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      note_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      note_q  <= note_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state and counter; stop overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_ACTIVE: begin
          if (!pause) begin
            if (last) begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          if (accept && dur_ok) begin
            state_d = ST_ACTIVE;
            cnt_d   = dur;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    ready_d = state_d != ST_ACTIVE;
    busy_d  = state_d == ST_ACTIVE;
    note_d  = busy_d && !hold && (cnt_d > GAP);
    err_d   = !stop && accept && !dur_ok;
    done_d  = (state_d == ST_DONE) || err_d;
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign note_on = note_q;
  assign done    = done_q;
  assign err     = err_q;

`ifndef SYNTHESIS
  localparam logic [64:0] CAP = 65'd1 << CNT_W;

  // Durations and the gap must fit in the counter.
  always_ff @(posedge clk) begin
    assert ((65'(QUARTER_CYCLES) * 65'd6 < CAP) && (65'(GAP_CYCLES) < CAP))
      else $error("beat_timer: CNT_W too narrow for configured durations");
  end
`endif

endmodule

// File: tb/tb_beat_timer.sv
// tb_beat_timer: directed and randomized checks of beat_timer against a
// cycle-ordinal reference model (Q=8, GAP=2).
module tb_beat_timer;

  localparam int Q = 8;
  localparam int G = 2;
  localparam int N = 120;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [3:0] beat   = 4'd0;
  logic       dotted = 1'b0;
  logic       pause  = 1'b0;
  logic       stop   = 1'b0;
  logic       ready, busy, note_on, done, err;

  int passed = 0;
  int total  = 0;

  beat_timer #(
    .CNT_W         (16),
    .QUARTER_CYCLES(Q),
    .GAP_CYCLES    (G)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .beat   (beat),
    .dotted (dotted),
    .pause  (pause),
    .stop   (stop),
    .ready  (ready),
    .busy   (busy),
    .note_on(note_on),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  function automatic int dur_of(input int code, input bit dot);
    int d;
    if (code < 1 || code > 6) return 0;
    d = (4 * Q) >> (code - 1);
`ifdef BEAT_TIMER_DOT_EN
    if (dot) d = d + d / 2;
`endif
    return d;
  endfunction

  // Cycle j is busy until D counted (non-paused) cycles have run; a cycle
  // with pause high does not count, and the registered tone output drops
  // in the cycle after pause is seen.
  function automatic void model(
    input  int           code,
    input  bit           dot,
    input  bit [N-1:0]   pm,
    input  int           stop_at,
    output logic [N-1:0] eb,
    output logic [N-1:0] eo,
    output logic [N-1:0] ed,
    output logic [N-1:0] ee,
    output logic [N-1:0] er
  );
    int d, k;
    bit act;
    eb = '0; eo = '0; ed = '0; ee = '0;
    d  = dur_of(code, dot);
    if (stop_at != 0) begin
      if (d == 0) begin
        ed[1] = 1'b1;
        ee[1] = 1'b1;
      end else begin
        k   = 0;
        act = 1'b1;
        for (int j = 1; j < N; j++) begin
          if (act) begin
            eb[j] = 1'b1;
            eo[j] = (k < d - G) && !(pm[j-1] && eb[j-1]);
            if (j == stop_at) act = 1'b0;
            else if (!pm[j]) begin
              k++;
              if (k == d) begin
                act = 1'b0;
                if (j + 1 < N) ed[j+1] = 1'b1;
              end
            end
          end
        end
      end
    end
    er = ~eb;
    er[0] = 1'b0;
  endfunction

  task automatic run_note(
    input  int           code,
    input  bit           dot,
    input  bit [N-1:0]   pm,
    input  int           stop_at,
    output logic [N-1:0] lb,
    output logic [N-1:0] lo,
    output logic [N-1:0] ld,
    output logic [N-1:0] le,
    output logic [N-1:0] lr
  );
    lb = '0; lo = '0; ld = '0; le = '0; lr = '0;
    @(posedge clk); #1;
    start  = 1'b1;
    beat   = 4'(code);
    dotted = dot;
    pause  = pm[0];
    stop   = (stop_at == 0);
    for (int j = 1; j < N; j++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      beat   = 4'($urandom);
      dotted = 1'($urandom);
      pause  = pm[j];
      stop   = (stop_at == j);
      @(negedge clk);
      lb[j] = busy;
      lo[j] = note_on;
      ld[j] = done;
      le[j] = err;
      lr[j] = ready;
    end
    @(posedge clk); #1;
    pause = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    beat  = 4'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (ready !== 1'b1) $display("FAIL reset ready: got %b want 1", ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
    total++; if (note_on !== 1'b0) $display("FAIL reset note_on: got %b want 0", note_on); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset err: got %b want 0", err); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_basic();
    logic [N-1:0] lb, lo, ld, le, lr;
    int eb_n, eo_n;
    run_note(3, 1'b0, '0, -1, lb, lo, ld, le, lr);
    total++; if (lb !== 120'h1FE) $display("FAIL q busy: got %h want %h", lb, 120'h1FE); else passed++;
    total++; if (lo !== 120'h7E) $display("FAIL q note_on: got %h want %h", lo, 120'h7E); else passed++;
    total++; if (ld !== 120'h200) $display("FAIL q done: got %h want %h", ld, 120'h200); else passed++;
    run_note(1, 1'b0, '0, -1, lb, lo, ld, le, lr);
    total++; if ($countones(lb) != 32) $display("FAIL whole busy: got %0d want 32", $countones(lb)); else passed++;
    run_note(3, 1'b1, '0, -1, lb, lo, ld, le, lr);
`ifdef BEAT_TIMER_DOT_EN
    eb_n = 12; eo_n = 10;
`else
    eb_n = 8; eo_n = 6;
`endif
    total++; if ($countones(lb) != eb_n) $display("FAIL dotted busy: got %0d want %0d", $countones(lb), eb_n); else passed++;
    total++; if ($countones(lo) != eo_n) $display("FAIL dotted note_on: got %0d want %0d", $countones(lo), eo_n); else passed++;
  endtask

  task automatic test_invalid();
    logic [N-1:0] lb, lo, ld, le, lr;
    int codes [4] = '{0, 9, 7, 15};
    foreach (codes[i]) begin
      run_note(codes[i], 1'b0, '0, -1, lb, lo, ld, le, lr);
      total++; if (le !== 120'h2) $display("FAIL inv%0d err: got %h want 2", codes[i], le); else passed++;
      total++; if (ld !== 120'h2) $display("FAIL inv%0d done: got %h want 2", codes[i], ld); else passed++;
      total++; if (lb !== '0) $display("FAIL inv%0d busy: got %h want 0", codes[i], lb); else passed++;
    end
    run_note(6, 1'b0, '0, -1, lb, lo, ld, le, lr);
    total++; if (lb !== 120'h2) $display("FAIL 32nd busy: got %h want 2", lb); else passed++;
    total++; if (lo !== '0) $display("FAIL 32nd note_on: got %h want 0", lo); else passed++;
  endtask

  task automatic test_pause();
    logic [N-1:0] lb, lo, ld, le, lr;
    run_note(3, 1'b0, 120'hF8, -1, lb, lo, ld, le, lr);
    total++; if ($countones(lb) != 13) $display("FAIL pause busy: got %0d want 13", $countones(lb)); else passed++;
    total++; if ((lo & 120'h1F0) !== '0) $display("FAIL pause note_on: got %h want 0 in %h", lo, 120'h1F0); else passed++;
    total++; if ($countones(lo) != 6) $display("FAIL pause tone len: got %0d want 6", $countones(lo)); else passed++;
    total++; if (ld !== 120'h4000) $display("FAIL pause done: got %h want %h", ld, 120'h4000); else passed++;
  endtask

  task automatic test_stop();
    logic [N-1:0] lb, lo, ld, le, lr;
    run_note(3, 1'b0, '0, 4, lb, lo, ld, le, lr);
    total++; if (lb !== 120'h1E) $display("FAIL stop busy: got %h want %h", lb, 120'h1E); else passed++;
    total++; if (lo !== 120'h1E) $display("FAIL stop note_on: got %h want %h", lo, 120'h1E); else passed++;
    total++; if (ld !== '0) $display("FAIL stop done: got %h want 0", ld); else passed++;
    total++; if (lr[5] !== 1'b1) $display("FAIL stop ready: got %b want 1", lr[5]); else passed++;
  endtask

  task automatic test_table();
    logic [N-1:0] lb, lo, ld, le, lr;
    logic [N-1:0] eb, eo, ed, ee, er;
    for (int c = 1; c <= 6; c++) begin
      for (int t = 0; t < 2; t++) begin
        model(c, 1'(t), '0, -1, eb, eo, ed, ee, er);
        run_note(c, 1'(t), '0, -1, lb, lo, ld, le, lr);
        total++; if (lb !== eb) $display("FAIL tab%0d.%0d busy: got %h want %h", c, t, lb, eb); else passed++;
        total++; if (lo !== eo) $display("FAIL tab%0d.%0d note_on: got %h want %h", c, t, lo, eo); else passed++;
        total++; if (ld !== ed) $display("FAIL tab%0d.%0d done: got %h want %h", c, t, ld, ed); else passed++;
        total++; if (lr !== er) $display("FAIL tab%0d.%0d ready: got %h want %h", c, t, lr, er); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int  nb;
    bit  got;
    @(posedge clk); #1;
    start = 1'b1; beat = 4'd5; dotted = 1'b0; pause = 1'b0; stop = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    total++; if (!got) $display("FAIL b2b first done: got 0 want 1"); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL b2b done ready: got %b want 1", ready); else passed++;
    start = 1'b1; beat = 4'd3; dotted = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL b2b contiguous busy: got %b want 1", busy); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL b2b ready: got %b want 0", ready); else passed++;
    nb  = 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
      else got = 1'b1;
    end
    total++; if (nb != 8) $display("FAIL b2b second busy: got %0d want 8", nb); else passed++;
    total++; if (done !== 1'b1) $display("FAIL b2b second done: got %b want 1", done); else passed++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; beat = 4'd1; dotted = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (busy !== 1'b1 || note_on !== 1'b1) $display("FAIL mid pre busy/on: got %b%b want 11", busy, note_on); else passed++;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if (ready !== 1'b1) $display("FAIL mid ready: got %b want 1", ready); else passed++;
    total++; if ({busy, note_on, done, err} !== 4'b0) $display("FAIL mid outs: got %b want 0000", {busy, note_on, done, err}); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid after: got %b%b want 00", busy, done); else passed++;
  endtask

  task automatic test_random();
    logic [N-1:0] lb, lo, ld, le, lr;
    logic [N-1:0] eb, eo, ed, ee, er;
    bit   [N-1:0] pm;
    int code, sa;
    bit dot;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) code = $urandom_range(0, 15);
      else code = $urandom_range(1, 6);
      dot = 1'($urandom);
      pm  = '0;
      for (int j = 0; j < 64; j++) pm[j] = ($urandom_range(0, 4) == 0);
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : -1;
      model(code, dot, pm, sa, eb, eo, ed, ee, er);
      run_note(code, dot, pm, sa, lb, lo, ld, le, lr);
      total++; if (lb !== eb) $display("FAIL rnd%0d busy: got %h want %h", i, lb, eb); else passed++;
      total++; if (lo !== eo) $display("FAIL rnd%0d note_on: got %h want %h", i, lo, eo); else passed++;
      total++; if (ld !== ed) $display("FAIL rnd%0d done: got %h want %h", i, ld, ed); else passed++;
      total++; if (le !== ee) $display("FAIL rnd%0d err: got %h want %h", i, le, ee); else passed++;
      total++; if (lr !== er) $display("FAIL rnd%0d ready: got %h want %h", i, lr, er); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_pause();
    test_stop();
    test_table();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
